inst_imm_encoder: RTL and testbench
===================================

Name: inst_imm_encoder

Overview:
- Streaming RV32I instruction encoder; the inverse of the immediate decoder in the decode stage.
- Accepts decoded fields (opcode, register indices, funct bits, signed 32-bit immediate) and packs them into a 32-bit instruction word.
- The immediate is scattered per format (I/S/B/J).
- Used by the instruction-memory preload path and by self-checking benches for encode→decode round trips.
- Valid/ready on both sides; 2-entry output buffer.

Parameters:
- DEPTH, 2, output buffer entries (power of 2, ≥2)
- CNT_W, 16, width of the encoded-beat counter

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  field bundle valid
- in_ready  output  1  encoder can accept a bundle
- in_opcode  input  7  RV32I opcode
- in_rd  input  5  destination register
- in_rs1  input  5  source register 1
- in_rs2  input  5  source register 2
- in_funct3  input  3  funct3
- in_funct7  input  7  funct7 (R-type only)
- in_imm  input  32  signed immediate, byte offset for B/J
- out_valid  output  1  encoded word valid
- out_ready  input  1  consumer accepts word
- out_inst  output  32  encoded instruction
- out_err  output  1  error flag for this beat
- enc_count  output  CNT_W  number of completed output handshakes

Behaviour:
- Reset (async, rst_n=0): buffer empty, out_valid=0, out_inst=0, out_err=0, enc_count=0, in_ready=1 once reset is released.
- Input handshake: in_valid & in_ready. Output handshake: out_valid & out_ready. out_inst and out_err stay stable while out_valid=1 and out_ready=0.
- in_ready = buffer not full. A simultaneous push and pop on a full buffer is not accepted; in_ready depends only on registered occupancy.
- Latency: a word accepted at edge N is visible at out_* after edge N when the buffer was empty (1 cycle). Order is FIFO.
- Encoding is combinational on the input side and stored in the buffer. Fields are placed as in standard RV32I:
  - I-type (0010011, 0000011, 1100111): imm[11:0]→[31:20], rs1→[19:15], funct3→[14:12], rd→[11:7].
  - S-type (0100011): imm[11:5]→[31:25], rs2→[24:20], rs1, funct3, imm[4:0]→[11:7].
  - B-type (1100011): imm[12]→[31], imm[10:5]→[30:25], rs2, rs1, funct3, imm[4:1]→[11:8], imm[11]→[7].
  - J-type (1101111): imm[20]→[31], imm[10:1]→[30:21], imm[11]→[20], imm[19:12]→[19:12], rd.
  - R-type (0110011): funct7, rs2, rs1, funct3, rd; in_imm ignored.
  - Opcode always goes to [6:0].
- Unsupported opcode: emitted with R layout, out_err=1.
- enc_count increments by 1 on each output handshake and wraps from all-ones to 0.
- State per entry: {inst[31:0], err}. Read and write pointers are log2(DEPTH)+1 bits; full/empty is derived from the pointer MSB.
- Reset mid-stream discards all buffered words; no partial output follows.

Optional Feature:
- Macro: INST_ENC_RANGE_CHECK_EN.
- Defined: out_err is also set for each of these cases:
  - I/S immediate outside [-2048, 2047]
  - B immediate outside [-4096, 4094] or odd
  - J immediate outside [-1048576, 1048574] or odd
  - Truncated bits are still encoded.
- Undefined: only the unsupported-opcode error exists; immediates are silently truncated.

Decomposition:
- Shared package rv32_pkg holds:
  - opcode localparams: OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH, OP_JAL, OP_REG
  - fmt_e enum {FMT_R, FMT_I, FMT_S, FMT_B, FMT_J, FMT_BAD}
  - immediate range constants
  The existing immediate decoder uses the same package.
- One sub-module, inst_enc_fifo: a generic DEPTH-entry synchronous FIFO of width 33. The encoder holds the combinational packer plus the counter.

Test Plan:
- Reset, then in_valid with opcode=0010011, rd=1, rs1=2, funct3=0, imm=-1 → after 1 cycle out_inst=32'hFFF10093, out_err=0, enc_count=1 after handshake.
- S-type: opcode=0100011, rs1=2, rs2=5, funct3=2, imm=8 → out_inst=32'h00512423.
- B-type imm=-4, rs1=1, rs2=2, funct3=0 → 32'hFE208EE3. J-type rd=1, imm=2048 → 32'h001000EF. Each output fed through the decoder returns the original immediate.
- Backpressure: out_ready=0, push 3 bundles → in_ready=0 after 2 accepted, third held. Then out_ready=1 → words drain in order; out_inst is stable while stalled.
- With INST_ENC_RANGE_CHECK_EN: I-type imm=2048 → out_err=1, out_inst[31:20]=12'h800. B-type imm=3 → out_err=1. Without the macro, both give out_err=0.
- Opcode 7'b1111111 → out_err=1. Assert rst_n=0 with 2 words buffered → out_valid=0 and enc_count=0 immediately (asynchronous).

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32I definitions for the instruction encoder and the immediate decoder.
// Holds the opcode constants, the instruction format enum, the immediate range limits,
// and a helper that maps an opcode to its format.
package rv32_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_J, FMT_BAD} fmt_e;

  // Representable immediate ranges; B/J limits are also required to be even.
  localparam int IMM_I_MIN = -2048;
  localparam int IMM_I_MAX = 2047;
  localparam int IMM_B_MIN = -4096;
  localparam int IMM_B_MAX = 4094;
  localparam int IMM_J_MIN = -1048576;
  localparam int IMM_J_MAX = 1048574;

  localparam int unsigned INST_W  = 32;
  localparam int unsigned ENTRY_W = INST_W + 1;

  function automatic fmt_e fmt_of(input logic [6:0] opcode);
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR: return FMT_I;
      OP_STORE:                 return FMT_S;
      OP_BRANCH:                return FMT_B;
      OP_JAL:                   return FMT_J;
      OP_REG:                   return FMT_R;
      default:                  return FMT_BAD;
    endcase
  endfunction

endpackage

// File: rtl/inst_enc_fifo.sv
// Generic DEPTH-entry synchronous FIFO used as the encoder output buffer.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push_valid_i/_o   write handshake (push_ready_o = not full)
//   push_data_i       entry to store
//   pop_valid_o/_i    read handshake (pop_valid_o = not empty)
//   pop_data_o        head entry, forced to zero while empty
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module inst_enc_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid_i,
  output logic             push_ready_o,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             pop_valid_o,
  input  logic             pop_ready_i,
  output logic [WIDTH-1:0] pop_data_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [WIDTH-1:0]   mem_d [DEPTH];
  logic               full, empty, push, pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                 (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

  // Ready depends only on registered occupancy: a pop in the same cycle does not
  // make room for a push into a full buffer.
  assign push_ready_o = !full;
  assign pop_valid_o  = !empty;
  assign push         = push_valid_i && !full;
  assign pop          = pop_ready_i && !empty;

  assign pop_data_o = empty ? '0 : mem_q[rd_ptr_q[PtrW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q[PtrW-1:0]] = push_data_i;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/inst_imm_encoder.sv
// Streaming RV32I instruction encoder: packs decoded fields and a signed immediate
// into a 32-bit instruction word, the inverse of the decode-stage immediate decoder.
// Optional feature macro: INST_ENC_RANGE_CHECK_EN (flags immediates that do not fit
// their format; truncated bits are still encoded).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        field bundle handshake
//   in_opcode .. in_imm        decoded fields
//   out_valid / out_ready      encoded word handshake
//   out_inst, out_err          encoded word and its error flag
//   enc_count                  completed output handshakes (wraps)
module inst_imm_encoder
  import rv32_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count
);

  fmt_e               fmt;
  logic [31:0]        inst_d;
  logic               err_d;
  logic [CNT_W-1:0]   enc_count_q, enc_count_d;
  logic [ENTRY_W-1:0] pop_data;

`ifdef INST_ENC_RANGE_CHECK_EN
  logic signed [31:0] imm_s;
  assign imm_s = in_imm;
`else
  // Upper immediate bits only matter to the range check.
  logic unused_imm_hi;
  assign unused_imm_hi = ^in_imm[31:21];
`endif

  always_comb begin
    fmt         = fmt_of(in_opcode);
    inst_d      = '0;
    inst_d[6:0] = in_opcode;
    err_d       = 1'b0;
    case (fmt)
      FMT_I: begin
        inst_d[31:20] = in_imm[11:0];
        inst_d[19:15] = in_rs1;
        inst_d[14:12] = in_funct3;
        inst_d[11:7]  = in_rd;
      end
      FMT_S: begin
        inst_d[31:25] = in_imm[11:5];
        inst_d[24:20] = in_rs2;
        inst_d[19:15] = in_rs1;
        inst_d[14:12] = in_funct3;
        inst_d[11:7]  = in_imm[4:0];
      end
      FMT_B: begin
        inst_d[31]    = in_imm[12];
        inst_d[30:25] = in_imm[10:5];
        inst_d[24:20] = in_rs2;
        inst_d[19:15] = in_rs1;
        inst_d[14:12] = in_funct3;
        inst_d[11:8]  = in_imm[4:1];
        inst_d[7]     = in_imm[11];
      end
      FMT_J: begin
        inst_d[31]    = in_imm[20];
        inst_d[30:21] = in_imm[10:1];
        inst_d[20]    = in_imm[11];
        inst_d[19:12] = in_imm[19:12];
        inst_d[11:7]  = in_rd;
      end
      default: begin
        // R-type and unsupported opcodes share the register layout.
        inst_d[31:25] = in_funct7;
        inst_d[24:20] = in_rs2;
        inst_d[19:15] = in_rs1;
        inst_d[14:12] = in_funct3;
        inst_d[11:7]  = in_rd;
        err_d         = (fmt == FMT_BAD);
      end
    endcase
`ifdef INST_ENC_RANGE_CHECK_EN
    case (fmt)
      FMT_I, FMT_S: begin
        if (imm_s < IMM_I_MIN || imm_s > IMM_I_MAX) err_d = 1'b1;
      end
      FMT_B: begin
        if (imm_s < IMM_B_MIN || imm_s > IMM_B_MAX || in_imm[0]) err_d = 1'b1;
      end
      FMT_J: begin
        if (imm_s < IMM_J_MIN || imm_s > IMM_J_MAX || in_imm[0]) err_d = 1'b1;
      end
      default: ;
    endcase
`endif
  end

  inst_enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_valid_i (in_valid),
    .push_ready_o (in_ready),
    .push_data_i  ({inst_d, err_d}),
    .pop_valid_o  (out_valid),
    .pop_ready_i  (out_ready),
    .pop_data_o   (pop_data)
  );

  assign out_inst = pop_data[ENTRY_W-1:1];
  assign out_err  = pop_data[0];

  always_comb begin
    enc_count_d = enc_count_q;
    if (out_valid && out_ready) enc_count_d = enc_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) enc_count_q <= '0;
    else        enc_count_q <= enc_count_d;
  end

  assign enc_count = enc_count_q;

endmodule

// File: tb/tb_inst_imm_encoder.sv
// Bench for inst_imm_encoder: fixed vectors, backpressure, reset mid-stream and a
// randomised stream, checked through a scoreboard queue plus a decode round trip.
module tb_inst_imm_encoder;
  import rv32_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [6:0]       in_opcode = '0;
  logic [4:0]       in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]       in_funct3 = '0;
  logic [6:0]       in_funct7 = '0;
  logic [31:0]      in_imm = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_inst;
  logic             out_err;
  logic [CNT_W-1:0] enc_count;

  inst_imm_encoder #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err),
    .enc_count (enc_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        err;
    fmt_e        fmt;
    logic [31:0] imm;  // immediate the decoder must recover
  } exp_t;

  exp_t             sb_q[$];
  exp_t             pending;
  int               n_cmp = 0;
  int               n_err = 0;
  logic [CNT_W-1:0] exp_count = '0;
  logic             hold_vld = 1'b0;
  logic [31:0]      hold_inst = '0;
  logic             hold_err = 1'b0;
  logic             rand_done = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic fmt_e tb_fmt(input logic [6:0] op);
    fmt_e f;
    f = FMT_BAD;
    if (op == 7'h13 || op == 7'h03 || op == 7'h67) f = FMT_I;
    if (op == 7'h23) f = FMT_S;
    if (op == 7'h63) f = FMT_B;
    if (op == 7'h6f) f = FMT_J;
    if (op == 7'h33) f = FMT_R;
    return f;
  endfunction

  function automatic exp_t model(input logic [6:0] op, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] imm);
    exp_t e;
    int   si;
    si     = $signed(imm);
    e.fmt  = tb_fmt(op);
    e.err  = 1'b0;
    e.imm  = '0;
    e.inst = {f7, rs2, rs1, f3, rd, op};
    case (e.fmt)
      FMT_I: begin
        e.inst = {imm[11:0], rs1, f3, rd, op};
        e.imm  = {{20{imm[11]}}, imm[11:0]};
`ifdef INST_ENC_RANGE_CHECK_EN
        e.err  = (si < -2048) || (si > 2047);
`endif
      end
      FMT_S: begin
        e.inst = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        e.imm  = {{20{imm[11]}}, imm[11:0]};
`ifdef INST_ENC_RANGE_CHECK_EN
        e.err  = (si < -2048) || (si > 2047);
`endif
      end
      FMT_B: begin
        e.inst = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        e.imm  = {{19{imm[12]}}, imm[12:1], 1'b0};
`ifdef INST_ENC_RANGE_CHECK_EN
        e.err  = (si < -4096) || (si > 4094) || imm[0];
`endif
      end
      FMT_J: begin
        e.inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        e.imm  = {{11{imm[20]}}, imm[20:1], 1'b0};
`ifdef INST_ENC_RANGE_CHECK_EN
        e.err  = (si < -1048576) || (si > 1048574) || imm[0];
`endif
      end
      FMT_BAD: e.err = 1'b1;
      default: ;
    endcase
    if (si == 32'h7fffffff) e.err = e.err;  // keeps si referenced in every build
    return e;
  endfunction

  // Independent immediate decoder, as in the decode stage.
  function automatic logic [31:0] tb_decode(input logic [31:0] w, input fmt_e f);
    case (f)
      FMT_I:   return {{20{w[31]}}, w[31:20]};
      FMT_S:   return {{20{w[31]}}, w[31:25], w[11:7]};
      FMT_B:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      FMT_J:   return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  // Monitor: handshakes seen at the negedge complete on the following posedge.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      check_eq("enc_count", 32'(enc_count), 32'(exp_count));
      if (hold_vld && out_valid) begin
        check_eq("stall_inst", out_inst, hold_inst);
        check_eq("stall_err", 32'(out_err), 32'(hold_err));
      end
      hold_vld  = out_valid && !out_ready;
      hold_inst = out_inst;
      hold_err  = out_err;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q.pop_front();
          check_eq("out_inst", out_inst, e.inst);
          check_eq("out_err", 32'(out_err), 32'(e.err));
          if (e.fmt != FMT_R && e.fmt != FMT_BAD) begin
            check_eq("imm_roundtrip", tb_decode(out_inst, e.fmt), e.imm);
          end
          exp_count = exp_count + 1'b1;
        end
      end
      if (in_valid && in_ready) sb_q.push_back(pending);
    end
  end

  // Called at posedge+1; returns at posedge+1 after acceptance.
  task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm, input exp_t e);
    int   cyc;
    logic acc;
    cyc       = 0;
    acc       = 1'b0;
    in_opcode = op;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
    pending   = e;
    in_valid  = 1'b1;
    while (!acc && cyc < 200) begin
      @(negedge clk);
      acc = in_ready;
      cyc++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) check_eq("in_accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic send_model(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [31:0] imm);
    drive(op, rd, rs1, rs2, f3, f7, imm, model(op, rd, rs1, rs2, f3, f7, imm));
  endtask

  task automatic send_exp(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] imm, input logic [31:0] x_inst, input logic x_err);
    exp_t e;
    e      = model(op, rd, rs1, rs2, f3, f7, imm);
    e.inst = x_inst;
    e.err  = x_err;
    drive(op, rd, rs1, rs2, f3, f7, imm, e);
  endtask

  task automatic wait_empty();
    int cyc;
    cyc = 0;
    while (sb_q.size() != 0 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq("drain_left", 32'(sb_q.size()), 32'd0);
  endtask

  logic range_on;

  initial begin
`ifdef INST_ENC_RANGE_CHECK_EN
    range_on = 1'b1;
`else
    range_on = 1'b0;
`endif
    #12;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_inst", out_inst, 32'd0);
    check_eq("rst_out_err", 32'(out_err), 32'd0);
    check_eq("rst_enc_count", 32'(enc_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Fixed vectors, consumer always ready.
    out_ready = 1'b1;
    send_exp(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hffffffff, 32'hfff10093, 1'b0);
    send_exp(7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd8, 32'h00512423, 1'b0);
    send_exp(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4, 32'hfe208ee3, 1'b0);
    send_exp(7'h6f, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h001000ef, 1'b0);
    send_exp(7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'h12345678, 32'h003100b3, 1'b0);
    send_exp(7'h7f, 5'd7, 5'd2, 5'd3, 3'd5, 7'h20, 32'd0, 32'h403153ff, 1'b1);
    send_exp(7'h13, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h80020193, range_on);
    send_exp(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 32'h00208163, range_on);
    wait_empty();

    // Backpressure: two accepted, third held until the consumer drains.
    out_ready = 1'b0;
    fork
      begin
        send_model(7'h03, 5'd9, 5'd10, 5'd0, 3'd2, 7'd0, 32'd100);
        send_model(7'h67, 5'd1, 5'd5, 5'd0, 3'd0, 7'd0, -32'sd16);
        send_model(7'h23, 5'd0, 5'd8, 5'd9, 3'd0, 7'd0, -32'sd2048);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        check_eq("bp_in_ready", 32'(in_ready), 32'd0);
        check_eq("bp_out_valid", 32'(out_valid), 32'd1);
        check_eq("bp_sb_depth", 32'(sb_q.size()), 32'd2);
        out_ready = 1'b1;
      end
    join
    wait_empty();

    // Randomised stream with a randomly stalling consumer.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [6:0]  op;
          logic [31:0] imm;
          case ($urandom_range(0, 7))
            0:       op = 7'h13;
            1:       op = 7'h03;
            2:       op = 7'h23;
            3:       op = 7'h63;
            4:       op = 7'h6f;
            5:       op = 7'h33;
            6:       op = 7'h67;
            default: op = 7'($urandom_range(0, 127));
          endcase
          if ($urandom_range(0, 3) == 0) imm = $urandom();
          else imm = 32'($signed(12'($urandom_range(0, 4095))));
          send_model(op, 5'($urandom()), 5'($urandom()), 5'($urandom()), 3'($urandom()),
                     7'($urandom()), imm);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_empty();

    // Asynchronous reset with two words buffered.
    out_ready = 1'b0;
    send_model(7'h13, 5'd4, 5'd4, 5'd0, 3'd1, 7'd0, 32'd5);
    send_model(7'h6f, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2);
    check_eq("pre_rst_in_ready", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_out_valid", 32'(out_valid), 32'd0);
    check_eq("async_enc_count", 32'(enc_count), 32'd0);
    check_eq("async_out_inst", out_inst, 32'd0);
    sb_q.delete();
    exp_count = '0;
    hold_vld  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("post_rst_out_valid", 32'(out_valid), 32'd0);
    send_model(7'h33, 5'd5, 5'd6, 5'd7, 3'd0, 7'h20, 32'd0);
    wait_empty();
    repeat (2) @(posedge clk);
    #1;
    check_eq("final_enc_count", 32'(enc_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
